// File: rtl/cnt_ctrl_pkg.sv
// Shared types and constants for the counter control unit (state encoding, mode values).
// Optional LED status port is enabled in the top by defining CNT_CTRL_LED_EN.
package cnt_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_RUN   = 2'b01,
    ST_CLEAR = 2'b10
  } cnt_state_t;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

  // Width of a divider counting 0..div-1, never narrower than one bit.
  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/cnt_tick_gen.sv
// Clock divider producing a registered one-cycle tick every DIV enabled cycles.
// i_clr restarts the phase; the divider holds its value while i_en is low.
module cnt_tick_gen
  import cnt_ctrl_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int              W    = div_width(DIV);
  localparam logic [W-1:0]    LAST = W'(DIV - 1);

  logic [W-1:0] r_div;
  logic         r_tick;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (i_en) begin
      r_tick <= (r_div == LAST);
      r_div  <= (r_div == LAST) ? '0 : r_div + 1'b1;
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/counter_ctrl_unit.sv
// Run/stop/clear/mode sequencer and tick source for the 0..9999 up/down counter.
// Define CNT_CTRL_LED_EN to add the one-hot o_led state display port.
module counter_ctrl_unit
  import cnt_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  output logic       o_tick,
  output logic       o_mode,
  output logic       o_clear,
  output logic       o_run
`ifdef CNT_CTRL_LED_EN
  ,
  output logic [2:0] o_led
`endif
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

  // Bit order in all button vectors: [2] mode, [1] clear, [0] run.
  logic [2:0] w_btn;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_s2_d;
  logic [2:0] w_press;

  cnt_state_t r_state;
  cnt_state_t w_next;
  logic       r_mode;
  logic       w_run;
  logic       w_tick;

  assign w_btn = {i_btn_mode, i_btn_clear, i_btn_run};

  // Flops reset high so a button held through reset needs a release before it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1   <= '1;
      r_s2   <= '1;
      r_s2_d <= '1;
    end else begin
      r_s1   <= w_btn;
      r_s2   <= r_s1;
      r_s2_d <= r_s2;
    end
  end

  assign w_press = r_s2 & ~r_s2_d;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_STOP;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_STOP: begin
        if      (w_press[1]) w_next = ST_CLEAR;
        else if (w_press[0]) w_next = ST_RUN;
      end
      ST_RUN: begin
        if      (w_press[1]) w_next = ST_CLEAR;
        else if (w_press[0]) w_next = ST_STOP;
      end
      ST_CLEAR: w_next = ST_STOP;
      default:  w_next = ST_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                 r_mode <= MODE_UP;
    else if (w_press[2] && r_state != ST_CLEAR) r_mode <= ~r_mode;
  end

  assign w_run   = (r_state == ST_RUN);
  assign o_run   = w_run;
  assign o_clear = (r_state == ST_CLEAR);
  assign o_mode  = r_mode;

  cnt_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_run),
    .i_clr  (o_clear),
    .o_tick (w_tick)
  );

  // A tick registered on the edge that leaves RUN is masked by the new state.
  assign o_tick = w_tick & w_run;

`ifdef CNT_CTRL_LED_EN
  assign o_led = {r_state == ST_CLEAR, r_state == ST_RUN, r_state == ST_STOP};
`endif

endmodule

// File: tb/tb_counter_ctrl_unit.sv
// Directed self-checking bench for counter_ctrl_unit with DIV = 10.
// Expected tick/clear cycles are queued when stimulus is driven and checked every cycle.
module tb_counter_ctrl_unit;

  localparam int DIV = 10;

  logic clk = 1'b0;
  logic rst;
  logic btnRun;
  logic btnClear;
  logic btnMode;
  logic oTick;
  logic oMode;
  logic oClear;
  logic oRun;
`ifdef CNT_CTRL_LED_EN
  logic [2:0] oLed;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic monEn = 1'b0;
  int tickQ[$];
  int clearQ[$];

  counter_ctrl_unit #(
    .CLK_FREQ_HZ (100),
    .TICK_HZ     (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn_run   (btnRun),
    .i_btn_clear (btnClear),
    .i_btn_mode  (btnMode),
    .o_tick      (oTick),
    .o_mode      (oMode),
    .o_clear     (oClear),
    .o_run       (oRun)
`ifdef CNT_CTRL_LED_EN
    ,
    .o_led       (oLed)
`endif
  );

  always #5 clk = ~clk;

  // cyc equals the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a one-cycle pulse on the selected buttons {mode, clear, run}; returns its sampling edge.
  task automatic applyStimulus(input logic [2:0] mask, output int sampleEdge);
    {btnMode, btnClear, btnRun} = mask;
    sampleEdge = cyc + 1;
    @(posedge clk);
    #1;
    {btnMode, btnClear, btnRun} = 3'b000;
  endtask

  // Scoreboard: o_tick and o_clear must be high exactly on queued cycles.
  always @(negedge clk) begin : monitor
    logic expTick;
    logic expClear;
    if (monEn) begin
      expTick  = (tickQ.size() > 0) && (tickQ[0] == cyc);
      expClear = (clearQ.size() > 0) && (clearQ[0] == cyc);
      if (expTick)  void'(tickQ.pop_front());
      if (expClear) void'(clearQ.pop_front());
      checkOutput("o_tick", 32'(oTick), 32'(expTick));
      checkOutput("o_clear", 32'(oClear), 32'(expClear));
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n, e, m, e2, p, q, dummy, e3, e4, n5;
    rst = 1'b1;
    {btnMode, btnClear, btnRun} = 3'b000;

    // Reset, then idle with buttons low.
    waitCycles(1);
    monEn = 1'b1;
    waitCycles(2);
    rst = 1'b0;
`ifdef CNT_CTRL_LED_EN
    checkOutput("led_reset", 32'(oLed), 32'd1);
`endif
    for (int i = 0; i < 50; i++) begin
      waitCycles(1);
      checkOutput("idle_run", 32'(oRun), 32'd0);
      checkOutput("idle_mode", 32'(oMode), 32'd0);
    end

    // Single-cycle run pulse: RUN two edges after sampling, tick every DIV cycles.
    applyStimulus(3'b001, n);
    e = n + 2;
    tickQ.push_back(e + DIV);
    tickQ.push_back(e + 2 * DIV);
    waitUntil(n + 1);
    checkOutput("run_latency_early", 32'(oRun), 32'd0);
    waitUntil(e);
    checkOutput("run_entered", 32'(oRun), 32'd1);
`ifdef CNT_CTRL_LED_EN
    checkOutput("led_run", 32'(oLed), 32'd2);
`endif

    // Stop after 25 RUN cycles: divider holds 5, so resume ticks after 5 cycles.
    m = e + 23;
    waitUntil(m - 1);
    applyStimulus(3'b001, dummy);
    waitUntil(m + 1);
    checkOutput("run_before_stop", 32'(oRun), 32'd1);
    waitUntil(m + 2);
    checkOutput("stopped", 32'(oRun), 32'd0);
    waitCycles(7);
    checkOutput("still_stopped", 32'(oRun), 32'd0);
    applyStimulus(3'b001, n);
    e2 = n + 2;
    tickQ.push_back(e2 + 5);
    tickQ.push_back(e2 + 5 + DIV);
    waitUntil(e2);
    checkOutput("resumed", 32'(oRun), 32'd1);

    // Mode toggles 0 -> 1 -> 0 -> 1 while running.
    waitUntil(e2 + 3);
    applyStimulus(3'b100, p);
    waitUntil(p + 1);
    checkOutput("mode_before_toggle", 32'(oMode), 32'd0);
    waitUntil(p + 2);
    checkOutput("mode_toggle1", 32'(oMode), 32'd1);
    checkOutput("run_during_mode", 32'(oRun), 32'd1);
    waitCycles(4);
    applyStimulus(3'b100, p);
    waitUntil(p + 2);
    checkOutput("mode_toggle2", 32'(oMode), 32'd0);
    waitCycles(3);
    applyStimulus(3'b100, p);
    waitUntil(p + 2);
    checkOutput("mode_toggle3", 32'(oMode), 32'd1);

    // Clear and run together on a tick edge: one clear pulse, tick masked, mode press in CLEAR dropped.
    q = e2 + 23;
    waitUntil(q - 1);
    applyStimulus(3'b011, dummy);
    clearQ.push_back(q + 2);
    applyStimulus(3'b100, dummy);
    waitUntil(q + 2);
    checkOutput("run_in_clear", 32'(oRun), 32'd0);
    checkOutput("mode_in_clear", 32'(oMode), 32'd1);
    waitUntil(q + 4);
    checkOutput("stop_after_clear", 32'(oRun), 32'd0);
    checkOutput("mode_kept_after_clear", 32'(oMode), 32'd1);

    // Divider restarted from 0; leaving RUN on a tick edge masks that tick.
    waitCycles(2);
    applyStimulus(3'b001, n);
    e3 = n + 2;
    tickQ.push_back(e3 + DIV);
    waitUntil(e3 + 17);
    applyStimulus(3'b001, dummy);
    waitUntil(e3 + 20);
    checkOutput("stop_on_tick_edge", 32'(oRun), 32'd0);
    waitCycles(4);
    applyStimulus(3'b001, n);
    e4 = n + 2;
    tickQ.push_back(e4 + DIV);
    waitUntil(e4);
    checkOutput("run_again", 32'(oRun), 32'd1);

    // Reset mid-RUN while holding run: STOP, mode cleared, held button ignored.
    waitUntil(e4 + 13);
    rst    = 1'b1;
    btnRun = 1'b1;
    waitCycles(1);
    checkOutput("rst_midrun_run", 32'(oRun), 32'd0);
    checkOutput("rst_midrun_mode", 32'(oMode), 32'd0);
    waitCycles(1);
    rst = 1'b0;
    waitCycles(10);
    checkOutput("held_btn_ignored", 32'(oRun), 32'd0);
    btnRun = 1'b0;
    waitCycles(5);
    checkOutput("release_no_run", 32'(oRun), 32'd0);
    applyStimulus(3'b001, n5);
    tickQ.push_back(n5 + 2 + DIV);
    waitUntil(n5 + 2);
    checkOutput("repress_run", 32'(oRun), 32'd1);
    waitUntil(n5 + 2 + DIV + 2);

    checkOutput("tick_queue_drained", 32'(tickQ.size()), 32'd0);
    checkOutput("clear_queue_drained", 32'(clearQ.size()), 32'd0);
    monEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
